// File: rtl/ram_loader_pkg.sv
// Package wrapper so modules can import the shared loader definitions.
package ram_loader_pkg;
    `include "ram_loader_defs.vh"
endpackage

// File: rtl/ram_loader_defs.vh
// State encodings and length constants shared by the ram_loader slice.
`ifndef RAM_LOADER_DEFS_VH
`define RAM_LOADER_DEFS_VH

localparam logic [2:0] S_LEN  = 3'd0;
localparam logic [2:0] S_LO   = 3'd1;
localparam logic [2:0] S_HI   = 3'd2;
localparam logic [2:0] S_CSUM = 3'd3;
localparam logic [2:0] S_DONE = 3'd4;
localparam logic [2:0] S_ERR  = 3'd5;

localparam int LEN_ZERO_WORDS = 256;

`endif

// File: rtl/ram_loader_word_assembler.sv
// word_assembler: low-byte latch plus the registered RAM write port (din/addr/we).
module word_assembler #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lo_load,
    input  logic [7:0]        lo_data,
    input  logic              hi_write,
    input  logic [7:0]        hi_data,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [15:0]       ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we
);
    logic [7:0]        lo_reg;
    logic [15:0]       din_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_reg   <= '0;
            din_reg  <= '0;
            addr_reg <= '0;
            we_reg   <= 1'b0;
        end else begin
            if (lo_load)
                lo_reg <= lo_data;
            // we is a single-cycle pulse; din/addr hold until the next word
            we_reg <= hi_write;
            if (hi_write) begin
                din_reg  <= {hi_data, lo_reg};
                addr_reg <= addr_in;
            end
        end
    end

    assign ram_din  = din_reg;
    assign ram_addr = addr_reg;
    assign ram_we   = we_reg;
endmodule

// File: rtl/ram_loader.sv
// Boot loader: length byte, then low/high byte pairs written to RAM from address 0.
// Optional trailing XOR checksum enabled by defining RAM_LOADER_CSUM_EN.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              error
);
    logic [2:0]        state_reg, state_next;
    logic [8:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic              lo_load;
    logic              word_write;
`ifdef RAM_LOADER_CSUM_EN
    logic [7:0]        acc_reg, acc_next;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wptr_next  = wptr_reg;
        lo_load    = 1'b0;
        word_write = 1'b0;
`ifdef RAM_LOADER_CSUM_EN
        acc_next   = acc_reg;
`endif
        case (state_reg)
            S_LEN: if (rx_valid) begin
                cnt_next   = (rx_data == 8'd0) ? 9'(LEN_ZERO_WORDS) : {1'b0, rx_data};
`ifdef RAM_LOADER_CSUM_EN
                acc_next   = 8'd0;
`endif
                state_next = S_LO;
            end
            S_LO: if (rx_valid) begin
                lo_load    = 1'b1;
`ifdef RAM_LOADER_CSUM_EN
                acc_next   = acc_reg ^ rx_data;
`endif
                state_next = S_HI;
            end
            S_HI: if (rx_valid) begin
                word_write = 1'b1;
                wptr_next  = wptr_reg + 1'b1;
                cnt_next   = cnt_reg - 9'd1;
`ifdef RAM_LOADER_CSUM_EN
                acc_next   = acc_reg ^ rx_data;
                state_next = (cnt_reg == 9'd1) ? S_CSUM : S_LO;
`else
                state_next = (cnt_reg == 9'd1) ? S_DONE : S_LO;
`endif
            end
`ifdef RAM_LOADER_CSUM_EN
            S_CSUM: if (rx_valid) begin
                state_next = (rx_data == acc_reg) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: state_next = state_reg;
`else
            S_CSUM, S_DONE, S_ERR: state_next = state_reg;
`endif
            default: state_next = S_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_LEN;
            cnt_reg   <= '0;
            wptr_reg  <= '0;
`ifdef RAM_LOADER_CSUM_EN
            acc_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wptr_reg  <= wptr_next;
`ifdef RAM_LOADER_CSUM_EN
            acc_reg   <= acc_next;
`endif
        end
    end

    word_assembler #(.ADDR_W(ADDR_W)) u_word_assembler (
        .clk      (clk),
        .rst_n    (rst_n),
        .lo_load  (lo_load),
        .lo_data  (rx_data),
        .hi_write (word_write),
        .hi_data  (rx_data),
        .addr_in  (wptr_reg),
        .ram_din  (ram_din),
        .ram_addr (ram_addr),
        .ram_we   (ram_we)
    );

    // Core stays in reset on error; only a clean load releases it.
    assign busy  = (state_reg != S_DONE);
    assign done  = (state_reg == S_DONE);
`ifdef RAM_LOADER_CSUM_EN
    assign error = (state_reg == S_ERR);
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed protocol cases plus randomized loads
// compared against a byte-stream protocol model.
module tb_ram_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [15:0] ram_din;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic        busy, done, error;

    ram_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_we(ram_we),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] addr; logic [15:0] din; } wr_t;
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    bit         exp_done, exp_err;
`ifdef RAM_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    always @(negedge clk) if (ram_we) got_q.push_back('{ram_addr, ram_din});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_din"},   {16'd0, ram_din}, 32'd0);
        chk({tag, "_addr"},  {24'd0, ram_addr}, 32'd0);
        chk({tag, "_we"},    {31'd0, ram_we}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        rx_data = 8'h5A; rx_valid = 1'b1;   // strobes during reset must be ignored
        tick(2);
        check_reset_vals("rst");
        rx_valid = 1'b0;
        rst_n = 1'b1;
        tick(1);
    endtask

    // Protocol model: interprets the byte stream directly.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = (stim_q[0] == 8'd0) ? 256 : int'(stim_q[0]);
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{8'(i % 256), {stim_q[2 + 2*i], stim_q[1 + 2*i]}});
            x = x ^ stim_q[1 + 2*i] ^ stim_q[2 + 2*i];
        end
        exp_err  = CSUM && (stim_q[1 + 2*n] !== x);
        exp_done = !exp_err;
    endtask

    task automatic do_load(input string tag, input bit do_reset, input int gap_max);
        wr_t last;
        if (do_reset) reset_dut();
        got_q.delete();
        model();
        for (int i = 0; i < stim_q.size(); i++) begin
            tick($urandom_range(gap_max, 0));
            if (i == stim_q.size() - 1)
                chk({tag, "_done_before_last"}, {31'd0, done}, 32'd0);
            send(stim_q[i]);
        end
        chk({tag, "_done"},  {31'd0, done},  {31'd0, exp_done});
        chk({tag, "_busy"},  {31'd0, busy},  {31'd0, !exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        tick(3);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (i < 4 || i >= exp_q.size() - 2 || got_q[i] !== exp_q[i])
                chk($sformatf("%s_wr%0d", tag, i), {8'd0, got_q[i]}, {8'd0, exp_q[i]});
        last = exp_q[exp_q.size() - 1];
        chk({tag, "_hold"}, {8'd0, ram_addr, ram_din}, {8'd0, last});
        chk({tag, "_we_idle"}, {31'd0, ram_we}, 32'd0);
        // terminal state: further bytes change nothing
        for (int i = 0; i < 5; i++) send(8'($urandom));
        tick(2);
        chk({tag, "_post_writes"}, got_q.size(), exp_q.size());
        chk({tag, "_post_state"}, {29'd0, done, busy, error}, {29'd0, exp_done, !exp_done, exp_err});
        $display("load %s words=%0d done=%0b error=%0b", tag, exp_q.size(), done, error);
    endtask

    task automatic gen_random(input int nwords, input bit bad);
        logic [7:0] x, b;
        stim_q.delete();
        stim_q.push_back(8'(nwords));
        x = 8'd0;
        for (int i = 0; i < 2 * nwords; i++) begin
            b = 8'($urandom);
            stim_q.push_back(b);
            x = x ^ b;
        end
        if (CSUM) stim_q.push_back(bad ? (x ^ 8'($urandom_range(255, 1))) : x);
    endtask

    initial begin
        tick(1);
        check_reset_vals("init");

        // basic two-word image
        stim_q = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        if (CSUM) stim_q.push_back(8'h40);
        do_load("basic", 1'b1, 0);

        // bad checksum: words still written, error raised
        if (CSUM) begin
            stim_q = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
            do_load("badcsum", 1'b1, 1);
        end

        // L=0 -> 256 words, word i = i
        stim_q.delete();
        stim_q.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            stim_q.push_back(8'(i));
            stim_q.push_back(8'h00);
        end
        if (CSUM) stim_q.push_back(8'h00);
        do_load("full256", 1'b1, 0);

        // reset mid-load abandons the partial image
        reset_dut();
        got_q.delete();
        send(8'h02); send(8'h34);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("midrst_nowrite", got_q.size(), 0);
        stim_q = '{8'h01, 8'hEF, 8'hBE};
        if (CSUM) stim_q.push_back(8'h51);
        do_load("afterrst", 1'b0, 0);

        // feature-off style single word
        stim_q = '{8'h01, 8'h78, 8'h56};
        if (CSUM) stim_q.push_back(8'h78 ^ 8'h56);
        do_load("oneword", 1'b1, 0);

        // randomized loads
        for (int t = 0; t < 6; t++) begin
            gen_random($urandom_range(40, 1), CSUM && (t % 3 == 2));
            do_load($sformatf("rand%0d", t), 1'b1, t % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
